uart_rx_serial: RTL and testbench

- Serial-line UART receiver: recovers frames from a single asynchronous `rx` wire and presents each byte on a valid/ready output.
- It is the far end of the team's UART transmitter path. It consumes a 16x oversampling tick from the baud generator.
- Does start-bit validation, 3-sample majority voting at mid-bit, optional parity checking and stop-bit (framing) checking.
- Each received byte is buffered in one output register, with an overrun indication.

---
 rtl/uart_rx_serial.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_serial.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_serial.sv
// Purpose: UART receiver; 16x oversampled, 3-sample mid-bit majority vote, optional parity, stop check.
// Latency: rx fall -> START in 3 clk; STOP decision os_tick -> rx_valid in 1 clk.
// Backpressure: one-word output register; a frame completing while a word is still held is dropped (overrun_err pulse).
//
// Ports:
//   clk, reset       system clock; asynchronous active-high reset
//   os_tick          one-clk pulse at OVERSAMPLE x baud
//   rx               asynchronous serial line, idles high
//   rx_ready         consumer accepts rx_data this cycle
//   rx_data          received word, LSB first on the line
//   rx_valid         rx_data and error flags valid
//   parity_err       parity mismatch for the held word
//   frame_err        stop bit sampled low for the held word
//   overrun_err      one-clk pulse when a completed frame was dropped
//   busy             FSM not IDLE
module uart_rx_serial #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Mid-bit sample points (7, 8, 9 for 16x) and the bit boundary.
  localparam logic [3:0] TICK_S0   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_S1   = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] TICK_VOTE = 4'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  // Input synchronizer and edge-detect history; all reset high so reset never looks like a start edge.
  logic sync1_q, rx_s_q, rx_d_q;

  state_t               state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic [3:0] tick_next;
  logic       at_vote, at_bound, vote, par_exp;
  logic       frame_done, frame_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;
    frame_bad    = 1'b0;
    par_exp      = 1'b0;

    tick_next = tick_q + 4'd1;
    at_vote   = os_tick && (tick_next == TICK_VOTE);
    at_bound  = os_tick && (tick_q == TICK_LAST);
    // Third sample is the live synchronized value on the voting tick.
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    if (state_q != IDLE && os_tick) begin
      tick_d = tick_next;
      if (tick_next == TICK_S0) samp_d[0] = rx_s_q;
      if (tick_next == TICK_S1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        // Falling edge only: a line stuck low cannot retrigger.
        if (rx_d_q && !rx_s_q) begin
          state_d = START;
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
        end else if (at_bound) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_vote) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_q == 3'(i)) shift_d[i] = vote;
          end
        end
        if (at_bound) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = 3'd0;
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (at_vote) begin
          if (PARITY_MODE == 1) par_exp = ~^shift_q;
          else                  par_exp = ^shift_q;
          perr_d = (vote != par_exp);
        end
        if (at_bound) state_d = STOP;
      end
      STOP: begin
        // Complete at mid-stop so the next start edge is seen even if the stop bit is short.
        if (at_vote) begin
          frame_done = 1'b1;
          frame_bad  = ~vote;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = frame_bad;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_q       <= 4'd0;
      bit_q        <= 3'd0;
      samp_q       <= 2'b11;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_serial.sv
// Purpose: scoreboard bench for uart_rx_serial (8 data bits, odd parity, os_tick every 4 clk).
// Latency: expected words queued at send time; monitor pops on each accepted handshake.
// Backpressure: rx_ready driven per test to exercise hold, overrun and same-cycle reload.
module tb_uart_rx_serial;

  localparam int BITCLK = 64;   // 16 os_ticks x 4 clk
  localparam int DECIDE = 169;  // os_ticks from START entry to the stop decision

  logic       clk = 1'b0;
  logic       reset, os_tick, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ovr_seen = 0;
  int   ovr0;
  bit   rdy_base = 1'b0;
  bit   trk_arm = 1'b0, trk_on = 1'b0, trk_hit = 1'b0;
  int   trk_wait = 0, trk_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_serial #(.DATA_BITS(8), .PARITY_MODE(1), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .os_tick     (os_tick),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: drive os_tick / rx_ready; optionally raise rx_ready on the exact stop-decision tick.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    os_tick  = (cyc % 4 == 0);
    rx_ready = rdy_base;
    if (trk_on) begin
      if (trk_wait > 0) trk_wait--;
      if (trk_wait == 0 && os_tick) begin
        trk_cnt++;
        if (trk_cnt == DECIDE) begin
          rx_ready = 1'b1;
          trk_hit  = 1'b1;
          trk_on   = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Frame on the line: start, 8 data LSB first, parity, stop; only the first nbits are sent.
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      step();
      rx = f[b];
      if (b == 0 && trk_arm) begin
        trk_on   = 1'b1;
        trk_wait = 3;
        trk_cnt  = 0;
        trk_arm  = 1'b0;
      end
      repeat (BITCLK - 1) step();
    end
  endtask

  always @(negedge clk) begin
    if (overrun_err) ovr_seen++;
    if (rx_valid && rx_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h, nothing expected", rx_data);
      end else begin
        e = q.pop_front();
        check("word_data", 32'(rx_data), 32'(e.d));
        check("word_perr", 32'(parity_err), 32'(e.pe));
        check("word_ferr", 32'(frame_err), 32'(e.fe));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    os_tick  = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    idle(5);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun_err), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    idle(20);
    rdy_base = 1'b1;

    // Good frame: 0xA5 has four ones, odd parity bit 1.
    q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send(8'hA5, 1'b1, 1'b1, 11);
    idle(64);

    // 0x3C has four ones, odd parity bit is 1; send 0 to force a parity error.
    q.push_back('{d: 8'h3C, pe: 1'b1, fe: 1'b0});
    send(8'h3C, 1'b0, 1'b1, 11);
    idle(64);

    // 0x00, correct parity 1, stop low, then line held low (break).
    q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    send(8'h00, 1'b1, 1'b0, 11);
    repeat (40 * BITCLK) step();
    check("break_busy", 32'(busy), 0);
    check("break_valid", 32'(rx_valid), 0);
    step();
    rx = 1'b1;
    idle(2 * BITCLK);

    // Glitch low for 3 os_ticks: false start.
    step();
    rx = 1'b0;
    repeat (11) step();
    check("glitch_busy_hi", 32'(busy), 1);
    step();
    rx = 1'b1;
    idle(60);
    check("glitch_busy_lo", 32'(busy), 0);
    check("glitch_valid", 32'(rx_valid), 0);

    // Overrun: 0x11 held, 0x22 dropped.
    rdy_base = 1'b0;
    ovr0 = ovr_seen;
    q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send(8'h11, 1'b1, 1'b1, 11);
    send(8'h22, 1'b1, 1'b1, 11);
    idle(16);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(ovr_seen - ovr0), 1);
    rdy_base = 1'b1;
    idle(2);
    rdy_base = 1'b0;
    idle(4);
    check("ovr_drained", 32'(rx_valid), 0);

    // Same again, but rx_ready pulses on the delivery clk: 0x22 replaces 0x11, no overrun.
    ovr0 = ovr_seen;
    q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send(8'h11, 1'b1, 1'b1, 11);
    q.push_back('{d: 8'h22, pe: 1'b0, fe: 1'b0});
    trk_arm = 1'b1;
    send(8'h22, 1'b1, 1'b1, 10);
    step();
    rx = 1'b1;
    for (int i = 0; i < 2 * BITCLK && !trk_hit; i++) step();
    check("deliver_clk_reached", 32'(trk_hit), 1);
    step();
    check("reload_valid", 32'(rx_valid), 1);
    check("reload_data", 32'(rx_data), 32'h22);
    check("reload_busy", 32'(busy), 0);
    idle(BITCLK);
    check("reload_no_ovr", 32'(ovr_seen - ovr0), 0);
    rdy_base = 1'b1;
    idle(4);

    // Reset mid-DATA with a word held in the output register.
    rdy_base = 1'b0;
    send(8'h77, 1'b1, 1'b1, 11);
    idle(16);
    check("pre_rst_valid", 32'(rx_valid), 1);
    check("pre_rst_data", 32'(rx_data), 32'h77);
    send(8'h5A, 1'b1, 1'b1, 4);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_data", 32'(rx_data), 0);
    check("mid_rst_perr", 32'(parity_err), 0);
    check("mid_rst_ferr", 32'(frame_err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    step();
    rx = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(20);
    rdy_base = 1'b1;
    q.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
    send(8'h81, 1'b1, 1'b1, 11);
    idle(64);

    check("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
